// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, FSM states and default width
// for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_signed(
    input muldiv_op_t op
  );
    return (op == OP_MULT) || (op == OP_MADD)
        || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 shift-add multiply step, or
// (with MULDIV_DIV_EN) one restoring-divide step.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] ph_i,
  input  logic [WIDTH-1:0] pl_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] ph_o,
  output logic [WIDTH-1:0] pl_o
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] trial;
`endif

  // Multiply: add multiplicand on lsb, shift pair right.
  // Divide: shift in dividend msb, subtract if it fits.
  always_comb begin
    sum  = {1'b0, ph_i}
         + {1'b0, (pl_i[0] ? m_i : '0)};
    ph_o = sum[WIDTH:1];
    pl_o = {sum[0], pl_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    trial = {ph_i, pl_i[WIDTH-1]} - {1'b0, m_i};
    if (div_i) begin
      if (!trial[WIDTH]) begin
        ph_o = trial[WIDTH-1:0];
        pl_o = {pl_i[WIDTH-2:0], 1'b1};
      end else begin
        ph_o = {ph_i[WIDTH-2:0], pl_i[WIDTH-1]};
        pl_o = {pl_i[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mul/div owning HI/LO.
// Optional divider datapath: MULDIV_DIV_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int DW = 2 * WIDTH;

  muldiv_state_t    state_q;
  muldiv_op_t       op_q;
  logic             ready_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] ph_q;
  logic [WIDTH-1:0] pl_q;
  logic [WIDTH-1:0] m_q;
  logic [DW-1:0]    acc_q;
  logic             sa_q;
  logic             sb_q;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic             bz_q;
  logic [WIDTH-1:0] q_c;
  logic [WIDTH-1:0] r_c;
`else
  logic             is_div;
`endif

  muldiv_op_t       op_in;
  logic             sgn_in;
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             is_mthi;
  logic             is_mtlo;
  logic             cnt_last;
  logic [WIDTH-1:0] ph_n;
  logic [WIDTH-1:0] pl_n;
  logic [DW-1:0]    prod;
  logic [DW-1:0]    sprod;
  logic [DW-1:0]    res_c;

  assign op_in   = muldiv_op_t'(Op);
  assign sgn_in  = op_signed(op_in);
  assign sa_in   = sgn_in & A[WIDTH-1];
  assign sb_in   = sgn_in & B[WIDTH-1];
  assign mag_a   = sa_in ? -A : A;
  assign mag_b   = sb_in ? -B : B;
  assign is_mthi = (op_in == OP_MTHI);
  assign is_mtlo = (op_in == OP_MTLO);
`ifndef MULDIV_DIV_EN
  assign is_div  = (op_in == OP_DIV)
                || (op_in == OP_DIVU);
`endif
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
`ifdef MULDIV_DIV_EN
    .div_i ((op_q == OP_DIV) || (op_q == OP_DIVU)),
`endif
    .ph_i  (ph_q),
    .pl_i  (pl_q),
    .m_i   (m_q),
    .ph_o  (ph_n),
    .pl_o  (pl_n)
  );

  // Final-step result: sign fix-up and accumulation.
  always_comb begin
    prod  = {ph_n, pl_n};
    sprod = (sa_q ^ sb_q) ? -prod : prod;
    res_c = sprod;
`ifdef MULDIV_DIV_EN
    q_c = (sa_q ^ sb_q) ? -pl_n : pl_n;
    r_c = sa_q ? -ph_n : ph_n;
`endif
    case (op_q)
      OP_MADD: res_c = acc_q + sprod;
      OP_MSUB: res_c = acc_q - sprod;
`ifdef MULDIV_DIV_EN
      OP_DIV,
      OP_DIVU: begin
        if (bz_q) res_c = {a_q, {WIDTH{1'b1}}};
        else      res_c = {r_c, q_c};
      end
`endif
      default: res_c = sprod;
    endcase
  end

  // Control FSM, iteration registers and HI/LO.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q     <= '0;
      bz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            ready_q <= 1'b0;
            unique case (1'b1)
              is_mthi: begin
                hi_q    <= A;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
              is_mtlo: begin
                lo_q    <= A;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
`ifndef MULDIV_DIV_EN
              is_div: begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
`endif
              default: begin
                op_q    <= op_in;
                sa_q    <= sa_in;
                sb_q    <= sb_in;
                ph_q    <= '0;
                pl_q    <= mag_a;
                m_q     <= mag_b;
                acc_q   <= {hi_q, lo_q};
                cnt_q   <= '0;
`ifdef MULDIV_DIV_EN
                a_q     <= A;
                bz_q    <= (B == '0);
`endif
                state_q <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          ph_q  <= ph_n;
          pl_q  <= pl_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_last) begin
            {hi_q, lo_q} <= res_c;
            cnt_q        <= '0;
            state_q      <= S_DONE;
            done_q       <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign Busy  = !ready_q;
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus random ops against an
// arithmetic reference model of HI/LO.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Ready, Busy, Done;
  logic [31:0] Hi, Lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  muldiv_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Ready (Ready),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] hl
  );
    logic [63:0] ps;
    int sa, sb;
    ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    sa = a;
    sb = b;
    case (op)
      3'd0: return ps;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: return hl + ps;
      3'd3: return hl - ps;
      3'd4: begin
        if (!DIV_EN) return hl;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd5: begin
        if (!DIV_EN) return hl;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return {a, hl[31:0]};
      default: return {hl[63:32], a};
    endcase
  endfunction

  task automatic run_op(input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    int lat;
    logic [63:0] exp;
    n = 0;
    while (!Ready && n < 100) begin
      @(posedge Clk); #1; n++;
    end
    chk("ready_before", 64'(Ready), 64'd1);
    exp = model(op, a, b, {mhi, mlo});
    if (op >= 3'd6 || (op >= 3'd4 && !DIV_EN))
      lat = 0;
    else
      lat = 32;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 100) begin
      @(posedge Clk); #1; n++;
    end
    chk($sformatf("lat_op%0d", op), 64'(n), 64'(lat));
    chk($sformatf("hi_op%0d", op), 64'(Hi),
        64'(exp[63:32]));
    chk($sformatf("lo_op%0d", op), 64'(Lo),
        64'(exp[31:0]));
    {mhi, mlo} = exp;
    @(posedge Clk); #1;
    chk("done_1cyc", 64'(Done), 64'd0);
    chk("ready_after", 64'(Ready), 64'd1);
  endtask

  initial begin
    int cnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    Start = 1'b1; Op = 3'd6; A = 32'hFFFF;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b0;
    @(posedge Clk); #1;
    chk("rst_drop_hi", 64'(Hi), 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFF_FFF1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(Lo), 64'h1);
    run_op(3'd6, 32'd0, 32'd0);
    run_op(3'd7, 32'd10, 32'd0);
    run_op(3'd2, 32'd2, 32'd3);
    chk("madd_hi", 64'(Hi), 64'd0);
    chk("madd_lo", 64'(Lo), 64'd16);
    run_op(3'd3, 32'd4, 32'd5);
    chk("msub_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("msub_lo", 64'(Lo), 64'hFFFF_FFFC);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    if (DIV_EN) begin
      chk("div_lo", 64'(Lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(Hi), 64'hFFFF_FFFF);
    end
    run_op(3'd4, 32'd7, 32'd0);
    if (DIV_EN) begin
      chk("div0_lo", 64'(Lo), 64'hFFFF_FFFF);
      chk("div0_hi", 64'(Hi), 64'd7);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    if (DIV_EN) begin
      chk("ovf_lo", 64'(Lo), 64'h8000_0000);
      chk("ovf_hi", 64'(Hi), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = rb >> 20;
      run_op(rop, ra, rb);
    end

    exp = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0,
                {mhi, mlo});
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1;
    A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("busy_mid", 64'(Busy), 64'd1);
    Start = 1'b1; Op = 3'd6; A = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Start = 1'b0;
    cnt = 0;
    repeat (60) begin
      if (Done) cnt++;
      @(posedge Clk); #1;
    end
    chk("one_done", 64'(cnt), 64'd1);
    chk("ign_hi", 64'(Hi), 64'(exp[63:32]));
    chk("ign_lo", 64'(Lo), 64'(exp[31:0]));
    {mhi, mlo} = exp;

    @(negedge Clk);
    Start = 1'b1; Op = 3'd0;
    A = 32'h0000_1234; B = 32'hFFFF_0001;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    chk("abort_ready", 64'(Ready), 64'd1);
    chk("abort_done", 64'(Done), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    mhi = '0; mlo = '0;
    cnt = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) cnt++;
    end
    chk("abort_nodone", 64'(cnt), 64'd0);
    chk("abort_idle", 64'(Ready), 64'd1);

    run_op(3'd2, 32'hFFFF_FFFF, 32'd7);
    run_op(3'd5, 32'd100, 32'd7);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
